// File: rtl/io_spi_port.sv
// Purpose : CPU I/O-mapped SPI master (mode 0, MSB first); data at BASE_PORT, status/control at BASE_PORT+1.
// Latency : transfer starts the cycle after the data-write tick; busy lasts exactly 16*DIV cycles.
// Backpres: no stall to the CPU; a data write while busy is dropped and flagged in the ovr status bit.
//
// Ports:
//   phi, reset                      clock and synchronous active-high reset
//   iorq_tick, iorq, rd, wr, a      CPU I/O cycle strobe, level request, qualifiers, low address byte
//   d_in / d_out, d_oe              CPU write data / read data with bus drive enable
//   spi_sck, spi_mosi, spi_miso     SPI mode-0 serial lines
//   spi_ss_n                        slave select, driven from the control register
module io_spi_port #(
    parameter logic [7:0] BASE_PORT = 8'h40,
    parameter int         DIV       = 2
) (
    input  logic       phi,
    input  logic       reset,
    input  logic       iorq_tick,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] a,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_ss_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [7:0] STAT_PORT = BASE_PORT + 8'd1;
    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       ss_n_q, ss_n_d;
    logic       ovr_q, ovr_d;

    logic sel_data, sel_stat;
    logic rd_tick, wr_tick;
    logic busy;
    logic phase_end;

    assign sel_data = (a == BASE_PORT);
    assign sel_stat = (a == STAT_PORT);

    // A tick with both or neither qualifier is not a valid access.
    assign rd_tick = iorq_tick & rd & ~wr;
    assign wr_tick = iorq_tick & wr & ~rd;

    // Busy spans the whole LOW/HIGH sequence, including the last HIGH cycle,
    // so a data write landing on the completing edge is still an overrun.
    assign busy      = (state_q != ST_IDLE);
    assign phase_end = (div_q == DIV_LAST);

    assign d_oe = iorq & rd & (sel_data | sel_stat);

    always_comb begin
        d_out = 8'h00;
        if (sel_data) begin
            d_out = rx_q;
        end else if (sel_stat) begin
            d_out = {busy, ovr_q, 5'b0, ~ss_n_q};
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ss_n_d  = ss_n_q;
        ovr_d   = ovr_q;

        if (wr_tick && sel_stat) begin
            ss_n_d = ~d_in[0];
        end
        // The CPU samples the status value during the tick; clearing takes effect after.
        if (rd_tick && sel_stat) begin
            ovr_d = 1'b0;
        end
        if (wr_tick && sel_data && busy) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_tick && sel_data) begin
                    state_d = ST_LOW;
                    shift_d = d_in;
                    mosi_d  = d_in[7];
                    bit_d   = 3'd0;
                    div_d   = 8'd0;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    state_d = ST_HIGH;
                    div_d   = 8'd0;
                    sck_d   = 1'b1;
                    shift_d = {shift_q[6:0], spi_miso};
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    div_d = 8'd0;
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_IDLE;
                        rx_d    = shift_q;
                        mosi_d  = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        // shift_q was already shifted on the rising edge, so bit 7 is the next bit out.
                        mosi_d  = shift_q[7];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge phi) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            rx_q    <= 8'h00;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            ss_n_q  <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            ovr_q   <= ovr_d;
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_io_spi_port.sv
// Bench for io_spi_port with BASE_PORT=40h, DIV=2: directed scenarios plus randomized
// transfers checked against a byte-level model (MOSI = tx MSB first, rx = MISO bits
// seen at each SCK rise, busy for 16*DIV cycles).
module tb_io_spi_port;

    localparam logic [7:0] DATA_P = 8'h40;
    localparam logic [7:0] STAT_P = 8'h41;
    localparam int         DIV    = 2;
    localparam int         BUSY_K = 16 * DIV + 1;
    localparam int         RISE_K = DIV + 1;

    logic       phi = 1'b0;
    logic       reset = 1'b1;
    logic       iorq_tick = 1'b0;
    logic       iorq = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic       d_oe;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_ss_n;

    logic miso_loop = 1'b1;
    logic miso_drv  = 1'b0;
    assign spi_miso = miso_loop ? spi_mosi : miso_drv;

    int n_cmp  = 0;
    int n_fail = 0;

    io_spi_port #(.BASE_PORT(8'h40), .DIV(DIV)) dut (
        .phi(phi), .reset(reset), .iorq_tick(iorq_tick), .iorq(iorq), .rd(rd), .wr(wr),
        .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss_n(spi_ss_n)
    );

    always #5 phi = ~phi;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All bus tasks are entered at a falling edge and return at the next falling edge.
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        iorq = 1'b1; wr = 1'b1; rd = 1'b0; a = addr; d_in = data; iorq_tick = 1'b1;
        @(negedge phi);
        iorq_tick = 1'b0; iorq = 1'b0; wr = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic oe);
        iorq = 1'b1; rd = 1'b1; wr = 1'b0; a = addr; iorq_tick = 1'b1;
        #1;
        data = d_out; oe = d_oe;
        @(negedge phi);
        iorq_tick = 1'b0; iorq = 1'b0; rd = 1'b0;
    endtask

    // Bus read without a tick: no side effects, no clock advance.
    task automatic peek(input logic [7:0] addr, output logic [7:0] data, output logic oe);
        iorq = 1'b1; rd = 1'b1; a = addr;
        #1;
        data = d_out; oe = d_oe;
        iorq = 1'b0; rd = 1'b0;
    endtask

    // Start a transfer and follow it to completion, recording MOSI at each SCK rise,
    // the cycle (relative to the start tick) of the first rise, and when busy drops.
    task automatic do_transfer(input logic [7:0] tx, input logic [7:0] pat, input logic loop,
                               output logic [7:0] mosi_seen, output int rises,
                               output int first_k, output int busy_k);
        logic       prev_sck;
        logic [7:0] st;
        logic       oe;
        logic [2:0] idx;
        mosi_seen = 8'h00; rises = 0; first_k = -1; busy_k = -1;
        miso_loop = loop;
        miso_drv  = pat[7];
        prev_sck  = spi_sck;
        io_write(DATA_P, tx);
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge phi);
            if (spi_sck && !prev_sck) begin
                if (rises < 8) begin
                    idx = 3'(7 - rises);
                    mosi_seen[idx] = spi_mosi;
                end
                if (first_k < 0) first_k = k;
                rises++;
            end
            prev_sck = spi_sck;
            if (rises < 8) begin
                idx = 3'(7 - rises);
                miso_drv = pat[idx];
            end
            peek(STAT_P, st, oe);
            if (!st[7]) begin
                busy_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        logic       oe;
        reset = 1'b1;
        repeat (2) @(negedge phi);
        reset = 1'b0;
        n_cmp++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got %b want 0", spi_sck); end
        n_cmp++; if (spi_mosi !== 1'b1) begin n_fail++; $display("FAIL reset_mosi got %b want 1", spi_mosi); end
        n_cmp++; if (spi_ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n got %b want 1", spi_ss_n); end
        io_read(STAT_P, v, oe);
        n_cmp++; if ({oe, v} !== 9'h100) begin n_fail++; $display("FAIL reset_stat got oe=%b %h want oe=1 00", oe, v); end
        io_read(DATA_P, v, oe);
        n_cmp++; if ({oe, v} !== 9'h100) begin n_fail++; $display("FAIL reset_data got oe=%b %h want oe=1 00", oe, v); end
    endtask

    task automatic test_basic;
        logic [7:0] ms, v;
        logic       oe;
        int         r, fk, bk;
        io_write(STAT_P, 8'h01);
        n_cmp++; if (spi_ss_n !== 1'b0) begin n_fail++; $display("FAIL basic_ss_n got %b want 0", spi_ss_n); end
        do_transfer(8'hA5, 8'h00, 1'b1, ms, r, fk, bk);
        n_cmp++; if (ms !== 8'hA5) begin n_fail++; $display("FAIL basic_mosi got %h want a5", ms); end
        n_cmp++; if (r !== 8) begin n_fail++; $display("FAIL basic_rises got %0d want 8", r); end
        n_cmp++; if (fk !== RISE_K) begin n_fail++; $display("FAIL basic_first_rise got %0d want %0d", fk, RISE_K); end
        n_cmp++; if (bk !== BUSY_K) begin n_fail++; $display("FAIL basic_busy_len got %0d want %0d", bk, BUSY_K); end
        io_read(DATA_P, v, oe);
        n_cmp++; if (v !== 8'hA5) begin n_fail++; $display("FAIL basic_rx got %h want a5", v); end
    endtask

    task automatic test_overrun;
        logic [7:0] v, st;
        logic       oe;
        int         done;
        miso_loop = 1'b1;
        io_write(DATA_P, 8'h96);
        repeat (5) @(negedge phi);
        io_write(DATA_P, 8'h3C);
        io_read(STAT_P, v, oe);
        n_cmp++; if (v !== 8'hC1) begin n_fail++; $display("FAIL ovr_stat_busy got %h want c1", v); end
        done = 0;
        for (int k = 0; k < 100; k++) begin
            peek(STAT_P, st, oe);
            if (!st[7]) begin done = 1; break; end
            @(negedge phi);
        end
        n_cmp++; if (done !== 1) begin n_fail++; $display("FAIL ovr_complete got busy stuck want idle"); end
        io_read(STAT_P, v, oe);
        n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL ovr_stat_after got %h want 01", v); end
        io_read(DATA_P, v, oe);
        n_cmp++; if (v !== 8'h96) begin n_fail++; $display("FAIL ovr_rx got %h want 96", v); end
    endtask

    // A data write on the very edge where busy clears is still dropped.
    task automatic test_busy_edge;
        logic [7:0] st, v;
        logic       oe;
        miso_loop = 1'b1;
        io_write(DATA_P, 8'h69);
        repeat (BUSY_K - 2) @(negedge phi);
        peek(STAT_P, st, oe);
        n_cmp++; if (st[7] !== 1'b1) begin n_fail++; $display("FAIL edge_last_busy got %b want 1", st[7]); end
        io_write(DATA_P, 8'h77);
        peek(STAT_P, st, oe);
        n_cmp++; if (st[7:6] !== 2'b01) begin n_fail++; $display("FAIL edge_busy_ovr got %b want 01", st[7:6]); end
        io_read(STAT_P, v, oe);
        n_cmp++; if (v !== 8'h41) begin n_fail++; $display("FAIL edge_stat got %h want 41", v); end
        io_read(DATA_P, v, oe);
        n_cmp++; if (v !== 8'h69) begin n_fail++; $display("FAIL edge_rx got %h want 69", v); end
    endtask

    task automatic test_no_effect;
        logic [7:0] st;
        logic       oe;
        iorq = 1'b1; wr = 1'b1; a = 8'h42; d_in = 8'hFF; iorq_tick = 1'b1;
        #1;
        n_cmp++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL noeff_42_oe got %b want 0", d_oe); end
        @(negedge phi);
        iorq_tick = 1'b0; iorq = 1'b0; wr = 1'b0;
        peek(STAT_P, st, oe);
        n_cmp++; if (st !== 8'h01) begin n_fail++; $display("FAIL noeff_42_stat got %h want 01", st); end
        rd = 1'b1; iorq = 1'b0; a = DATA_P;
        #1;
        n_cmp++; if (d_oe !== 1'b0) begin n_fail++; $display("FAIL noeff_noiorq_oe got %b want 0", d_oe); end
        rd = 1'b0;
        // Tick with neither qualifier on the data port: must not start a transfer.
        iorq = 1'b1; a = DATA_P; d_in = 8'h81; iorq_tick = 1'b1;
        @(negedge phi);
        iorq_tick = 1'b0; iorq = 1'b0;
        // Tick with both qualifiers on the status port: must not change ss.
        iorq = 1'b1; rd = 1'b1; wr = 1'b1; a = STAT_P; d_in = 8'h00; iorq_tick = 1'b1;
        @(negedge phi);
        iorq_tick = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0;
        peek(STAT_P, st, oe);
        n_cmp++; if (st !== 8'h01) begin n_fail++; $display("FAIL noeff_bad_qual got %h want 01", st); end
    endtask

    task automatic test_ff_miso0;
        logic [7:0] ms, v;
        logic       oe;
        int         r, fk, bk;
        do_transfer(8'hFF, 8'h00, 1'b0, ms, r, fk, bk);
        n_cmp++; if (ms !== 8'hFF) begin n_fail++; $display("FAIL ff_mosi got %h want ff", ms); end
        io_read(DATA_P, v, oe);
        n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL ff_rx got %h want 00", v); end
    endtask

    task automatic test_reset_mid;
        logic       prev_sck;
        logic [7:0] st, ms, v, tx;
        logic       oe;
        int         rises, r, fk, bk;
        miso_loop = 1'b1;
        rises = 0;
        prev_sck = spi_sck;
        io_write(DATA_P, 8'hC3);
        for (int k = 0; k < 100; k++) begin
            if (spi_sck && !prev_sck) rises++;
            prev_sck = spi_sck;
            if (rises == 4) break;
            @(negedge phi);
        end
        n_cmp++; if (rises !== 4) begin n_fail++; $display("FAIL mid_4th_rise got %0d rises want 4", rises); end
        // Reset together with a data-write tick: reset must win.
        reset = 1'b1;
        iorq = 1'b1; wr = 1'b1; a = DATA_P; d_in = 8'h11; iorq_tick = 1'b1;
        @(negedge phi);
        reset = 1'b0; iorq_tick = 1'b0; iorq = 1'b0; wr = 1'b0;
        n_cmp++; if ({spi_sck, spi_mosi, spi_ss_n} !== 3'b011) begin
            n_fail++; $display("FAIL mid_pins got sck/mosi/ss_n=%b%b%b want 011", spi_sck, spi_mosi, spi_ss_n);
        end
        peek(STAT_P, st, oe);
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL mid_stat got %h want 00", st); end
        peek(DATA_P, st, oe);
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL mid_rx got %h want 00", st); end
        io_write(STAT_P, 8'h01);
        tx = 8'($urandom);
        do_transfer(tx, 8'h00, 1'b1, ms, r, fk, bk);
        n_cmp++; if (bk !== BUSY_K) begin n_fail++; $display("FAIL mid_after_busy got %0d want %0d", bk, BUSY_K); end
        io_read(DATA_P, v, oe);
        n_cmp++; if (v !== tx) begin n_fail++; $display("FAIL mid_after_rx got %h want %h", v, tx); end
    endtask

    task automatic test_random;
        logic [7:0] tx, pat, ms, v, exp_rx;
        logic       loop, oe;
        int         r, fk, bk;
        for (int i = 0; i < 8; i++) begin
            tx   = 8'($urandom);
            pat  = 8'($urandom);
            loop = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge phi);
            exp_rx = loop ? tx : pat;
            do_transfer(tx, pat, loop, ms, r, fk, bk);
            n_cmp++; if (ms !== tx) begin n_fail++; $display("FAIL rnd%0d_mosi got %h want %h", i, ms, tx); end
            n_cmp++; if (r !== 8) begin n_fail++; $display("FAIL rnd%0d_rises got %0d want 8", i, r); end
            n_cmp++; if (bk !== BUSY_K) begin n_fail++; $display("FAIL rnd%0d_busy got %0d want %0d", i, bk, BUSY_K); end
            io_read(DATA_P, v, oe);
            n_cmp++; if (v !== exp_rx) begin n_fail++; $display("FAIL rnd%0d_rx got %h want %h", i, v, exp_rx); end
        end
    endtask

    initial begin
        repeat (3) @(negedge phi);
        test_reset;
        test_basic;
        test_overrun;
        test_busy_edge;
        test_no_effect;
        test_ff_miso0;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_spi_port.md
IO_SPI_PORT -- requirements
Module: io_spi_port

Interface
REQ-001 Parameter BASE_PORT, default 8'h40, I/O port of the data register; the status/control register is at BASE_PORT+1.
REQ-002 Parameter DIV, default 2, range 1..255, SCK half-period in phi cycles.
REQ-003 phi  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iorq_tick  input  1  single-phi-cycle strobe from iorq_fsm; at most one per CPU I/O cycle.
REQ-006 iorq  input  1  active-high level I/O request, raw from the CPU.
REQ-007 rd  input  1  active-high read qualifier for the current I/O cycle.
REQ-008 wr  input  1  active-high write qualifier for the current I/O cycle.
REQ-009 a  input  8  low I/O address byte.
REQ-010 d_in  input  8  CPU write data, valid while iorq_tick is high.
REQ-011 d_out  output  8  read data to the CPU bus.
REQ-012 d_oe  output  1  bus drive enable for d_out.
REQ-013 spi_sck  output  1  SPI clock, mode 0.
REQ-014 spi_mosi  output  1  SPI data out, MSB first.
REQ-015 spi_miso  input  1  SPI data in; it is synchronous to phi and needs no synchronizer.
REQ-016 spi_ss_n  output  1  active-low slave select.

Function
REQ-017 Address match: sel_data = (a==BASE_PORT), sel_stat = (a==BASE_PORT+1); other addresses have no effect.
REQ-018 d_oe SHALL be combinational: iorq & rd & (sel_data | sel_stat); d_out = rx_reg on sel_data and {busy, ovr, 5'b0, ss} on sel_stat, and 8'h00 otherwise.
REQ-019 Write to the status port (iorq_tick & wr & sel_stat): ss <= d_in[0]; spi_ss_n = ~ss, registered; this is accepted whether or not busy is set.
REQ-020 Read of the status port (iorq_tick & rd & sel_stat): ovr clears in the following cycle, after the CPU has sampled the value.
REQ-021 Write to the data port while idle (iorq_tick & wr & sel_data & ~busy): the transfer starts; shift_reg <= d_in; busy <= 1 on the next cycle.
REQ-022 Write to the data port while busy SHALL be dropped; ovr <= 1; the transfer in progress is undisturbed.
REQ-023 FSM states: IDLE, LOW, HIGH; a DIV-cycle divider counter times each LOW and HIGH phase.
- IDLE: sck=0, mosi=1, busy=0.
- Start: go to LOW; mosi=shift_reg[7]; bit count=0.
REQ-024 LOW -> HIGH after DIV cycles; on that edge sck <= 1 and spi_miso is sampled into shift_reg[0] as the register shifts left.
REQ-025 HIGH -> LOW after DIV cycles while bit count<7; sck <= 0; mosi <= next bit; bit count increments.
REQ-026 HIGH -> IDLE after the 8th HIGH phase.
- On that edge: rx_reg <= received byte; busy <= 0; sck <= 0; mosi <= 1.
REQ-027 Latency: if the start tick is in cycle N, busy is high from N+1 and goes low at N+1+16*DIV, exactly.
- The first sck rise is at N+1+DIV.
REQ-028 A data write tick in the same cycle busy clears counts as busy: it is dropped and ovr is set.
REQ-029 Reads of the data port have no side effects; rx_reg holds its value until the next transfer completes.
REQ-030 Any tick with rd=wr=0, or with both set, SHALL be ignored.

Reset
REQ-031 Reset SHALL force the following on the next phi edge, including mid-transfer: state=IDLE, sck=0, mosi=1, spi_ss_n=1, busy=0, ovr=0, rx_reg=8'h00, shift_reg=8'h00, counters=0.
REQ-032 Reset has priority over a coincident iorq_tick.

Verification (BASE_PORT=8'h40, DIV=2)
REQ-033 Reset pulse -> spi_sck=0, spi_mosi=1, spi_ss_n=1; a status read returns 8'h00; a data read returns 8'h00.
REQ-034 Write 8'h01 to port 41h, then 8'hA5 to port 40h with miso looped to mosi.
- ss_n goes 0 after the first write.
- There are 8 sck pulses; mosi at each rise is 1,0,1,0,0,1,0,1.
- busy clears 33 cycles after the tick.
- A data read then returns 8'hA5.
REQ-035 Write 8'h3C to port 40h during a transfer.
- A status read returns 8'hC1.
- The next status read, after completion, returns 8'h01.
- rx_reg holds only the first byte.
REQ-036 Assert reset at the 4th sck rise of a transfer -> IDLE on the next edge with all outputs at reset values; a subsequent transfer completes normally.
REQ-037 Accesses that SHALL have no effect and leave d_oe=0:
- a write tick to port 42h;
- rd high with iorq low at port 40h.
REQ-038 With miso tied 0, write 8'hFF -> mosi is high for all 8 bits; a data read returns 8'h00.
